replacement_controller: RTL and testbench
=========================================

# replacement_controller

Miss/hit sequencer that sits between a set-associative cache's tag-compare stage and its `LRU` replacement-state block. On hits it forwards the hit way to `LRU` as an access update. On misses it picks a victim way: the lowest invalid way if one exists, otherwise the way reported by `LRU`. It then runs an optional dirty writeback and a refill through two req/ack handshakes, and finally marks the victim as most-recently used.

## Interface
- `NUM_WAYS`, 4, cache associativity (power of two, ≥2)
- `INDEX_BITS`, 8, set-index width
- `clock`  in  1  single clock; all logic rising-edge
- `reset`  in  1  synchronous, active-high
- `lookup_valid`  in  1  tag-compare result valid this cycle
- `lookup_index`  in  INDEX_BITS  set of the lookup
- `hit`  in  1  lookup hit
- `hit_way`  in  log2(NUM_WAYS)  way that hit (meaningful when `hit`=1)
- `valid_bits`  in  NUM_WAYS  valid bits of the looked-up set
- `dirty_bits`  in  NUM_WAYS  dirty bits of the looked-up set
- `ready`  out  1  controller can accept a lookup
- `lru_index`  out  INDEX_BITS  drives `LRU.current_index`
- `lru_access`  out  log2(NUM_WAYS)  drives `LRU.access`
- `lru_access_valid`  out  1  drives `LRU.access_valid`
- `lru_onehot`  in  NUM_WAYS  `LRU.lru` (one-hot least-recently-used way)
- `victim_way`  out  log2(NUM_WAYS)  selected victim, stable from SELECT until DONE
- `wb_req` / `wb_ack`  out / in  1 / 1  writeback handshake
- `refill_req` / `refill_ack`  out / in  1 / 1  refill handshake
- `miss_done`  out  1  one-cycle pulse when miss handling completes

## Operation
- FSM states: IDLE, SELECT, WRITEBACK, REFILL, UPDATE.
- IDLE (`ready`=1):
  - `lookup_valid`&`hit` → stay IDLE; next cycle `lru_access`=`hit_way`, `lru_index`=`lookup_index`, `lru_access_valid`=1 for exactly one cycle.
  - `lookup_valid`&!`hit` → latch index, `valid_bits` and `dirty_bits`; `lru_index` ← index; go to SELECT.
- SELECT (one cycle; samples `lru_onehot` for the latched index):
  - If any latched valid bit is 0, victim = lowest-numbered invalid way.
  - Otherwise victim = lowest set bit of `lru_onehot`. An all-zero `lru_onehot` selects way 0.
  - Next state is WRITEBACK if the victim is valid and dirty, else REFILL.
- WRITEBACK: `wb_req`=1 until `wb_ack` is sampled high, then REFILL.
- REFILL: `refill_req`=1 until `refill_ack` is sampled high, then UPDATE.
- UPDATE: `lru_access`=victim, `lru_access_valid`=1, `miss_done`=1, each for one cycle; return to IDLE.
- `ready`=0 in every state except IDLE. A `lookup_valid` arriving when not ready is ignored; the requester holds it.
- Victim-select priority: the invalid-way fill takes precedence over LRU. Within each category the lowest index wins, so multi-hot `lru_onehot` resolves deterministically.

## Timing
- Reset values: state=IDLE; `ready`=1; `lru_index`=0; `lru_access`=0; `victim_way`=0; `lru_access_valid`=`wb_req`=`refill_req`=`miss_done`=0.
- All outputs are registered.
- Hit: lookup accepted at edge N; `lru_access_valid` high during cycle N+1.
- Miss latency, clean victim with zero-wait ack: accepted at edge N; SELECT in cycle N+1; `refill_req` high from N+2; ack sampled at edge N+2; UPDATE/`miss_done` in cycle N+3; `ready` high again in N+4.
- A dirty victim adds the writeback handshake duration, minimum one cycle.
- Handshakes:
  - req rises on entry to its state.
  - ack is sampled only while req is high.
  - req drops in the cycle after ack is sampled.
  - An ack arriving while req is low is ignored.
  - wb and refill requests never overlap.
- Reset asserted mid-operation: the FSM goes to IDLE on that edge, all reqs drop, and no `miss_done` or LRU update is issued.
- Back-to-back hits: one LRU update per cycle, no bubbles.

## Structure
- Shared package `cache_repl_pkg`:
  - FSM state encoding
  - `log2` function
  - `onehot_to_bin` / lowest-set-bit function
- One sub-module, `lowest_set_encoder` (parameter WIDTH): a combinational priority encoder returning the index and an `any` flag. It is instantiated twice, once on the inverted latched valid bits and once on `lru_onehot`.
- The existing `LRU` module is instantiated by the parent, not inside this block.

## Test plan
- Reset, then hit on way 2 at index 1 → next cycle `lru_access`=2, `lru_index`=1, `lru_access_valid`=1 for exactly one cycle; `ready` stays 1.
- Miss with `valid_bits`=4'b1011, `lru_onehot`=4'b1000 → `victim_way`=2; no `wb_req`; `refill_req` asserted; after ack, `lru_access`=2 and `miss_done` pulse.
- Miss with `valid_bits`=4'b1111, `dirty_bits`=4'b0001, `lru_onehot`=4'b0001 → `victim_way`=0; `wb_req` held 3 cycles until a delayed ack; then refill; then update way 0.
- Miss with all valid, clean, `lru_onehot`=4'b1000 and zero-wait acks → `miss_done` exactly 3 cycles after acceptance; the `lookup_valid` asserted during busy cycles is not accepted.
- Reset asserted while `wb_req`=1 → next cycle state IDLE, `wb_req`=0, `ready`=1, no `miss_done`/`lru_access_valid`.
- `lru_onehot`=4'b0110 (multi-hot) and 4'b0000 with all ways valid → victim 1 and victim 0 respectively.

Source files
------------

// File: rtl/cache_repl_pkg.sv
// Shared definitions for the cache replacement controller: FSM encoding and
// small bit-manipulation helpers used for victim selection.
package cache_repl_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SELECT    = 3'd1;
  localparam logic [2:0] S_WRITEBACK = 3'd2;
  localparam logic [2:0] S_REFILL    = 3'd3;
  localparam logic [2:0] S_UPDATE    = 3'd4;

  // Upper bound on vector width handled by onehot_to_bin (associativity cap).
  localparam int unsigned MAX_VEC_BITS = 64;

  // Ceiling log2; constant-evaluable for port and parameter widths.
  function automatic int unsigned log2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic int unsigned onehot_to_bin(input logic [MAX_VEC_BITS-1:0] vec);
    for (int unsigned i = 0; i < MAX_VEC_BITS; i++) begin
      if (vec[i]) return i;
    end
    return 0;
  endfunction

endpackage

// File: rtl/lowest_set_encoder.sv
// Combinational priority encoder: index of the lowest set bit plus an any flag.
module lowest_set_encoder
  import cache_repl_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0]        bits,
  output logic [log2(WIDTH)-1:0]  index,
  output logic                    any
);

  localparam int unsigned IDX_W = log2(WIDTH);

  always_comb begin
    index = IDX_W'(onehot_to_bin(MAX_VEC_BITS'(bits)));
    any   = |bits;
  end

endmodule

// File: rtl/replacement_controller.sv
// Hit/miss sequencer between tag compare and the LRU block: forwards hits as
// LRU updates, and on misses picks a victim, runs writeback/refill, then updates LRU.
module replacement_controller
  import cache_repl_pkg::*;
#(
  parameter int unsigned NUM_WAYS   = 4,
  parameter int unsigned INDEX_BITS = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         lookup_valid,
  input  logic [INDEX_BITS-1:0]        lookup_index,
  input  logic                         hit,
  input  logic [log2(NUM_WAYS)-1:0]    hit_way,
  input  logic [NUM_WAYS-1:0]          valid_bits,
  input  logic [NUM_WAYS-1:0]          dirty_bits,
  output logic                         ready,
  output logic [INDEX_BITS-1:0]        lru_index,
  output logic [log2(NUM_WAYS)-1:0]    lru_access,
  output logic                         lru_access_valid,
  input  logic [NUM_WAYS-1:0]          lru_onehot,
  output logic [log2(NUM_WAYS)-1:0]    victim_way,
  output logic                         wb_req,
  input  logic                         wb_ack,
  output logic                         refill_req,
  input  logic                         refill_ack,
  output logic                         miss_done
);

  localparam int unsigned WAY_BITS = log2(NUM_WAYS);

  logic [2:0]          state;
  logic [NUM_WAYS-1:0] valid_q;
  logic [NUM_WAYS-1:0] dirty_q;
  logic [NUM_WAYS-1:0] invalid_q;
  logic [WAY_BITS-1:0] inv_idx;
  logic [WAY_BITS-1:0] lru_idx;
  logic                inv_any;
  logic                lru_any;
  logic [WAY_BITS-1:0] sel_victim;
  logic                sel_dirty;

  assign invalid_q = ~valid_q;

  lowest_set_encoder #(.WIDTH(NUM_WAYS)) u_invalid_enc (
    .bits  (invalid_q),
    .index (inv_idx),
    .any   (inv_any)
  );

  lowest_set_encoder #(.WIDTH(NUM_WAYS)) u_lru_enc (
    .bits  (lru_onehot),
    .index (lru_idx),
    .any   (lru_any)
  );

  // Invalid-way fill beats LRU; an empty LRU vector encodes to way 0.
  always_comb begin
    sel_victim = inv_any ? inv_idx : (lru_any ? lru_idx : '0);
    sel_dirty  = !inv_any && dirty_q[sel_victim];
  end

  // lru_index doubles as the latched miss index: it only changes in IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= S_IDLE;
      ready            <= 1'b1;
      lru_index        <= '0;
      lru_access       <= '0;
      lru_access_valid <= 1'b0;
      victim_way       <= '0;
      wb_req           <= 1'b0;
      refill_req       <= 1'b0;
      miss_done        <= 1'b0;
      valid_q          <= '0;
      dirty_q          <= '0;
    end else begin
      lru_access_valid <= 1'b0;
      miss_done        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (lookup_valid) begin
            lru_index <= lookup_index;
            if (hit) begin
              lru_access       <= hit_way;
              lru_access_valid <= 1'b1;
            end else begin
              valid_q <= valid_bits;
              dirty_q <= dirty_bits;
              ready   <= 1'b0;
              state   <= S_SELECT;
            end
          end
        end
        S_SELECT: begin
          victim_way <= sel_victim;
          if (sel_dirty) begin
            wb_req <= 1'b1;
            state  <= S_WRITEBACK;
          end else begin
            refill_req <= 1'b1;
            state      <= S_REFILL;
          end
        end
        S_WRITEBACK: begin
          if (wb_req && wb_ack) begin
            wb_req     <= 1'b0;
            refill_req <= 1'b1;
            state      <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (refill_req && refill_ack) begin
            refill_req       <= 1'b0;
            lru_access       <= victim_way;
            lru_access_valid <= 1'b1;
            miss_done        <= 1'b1;
            state            <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          wb_req     <= 1'b0;
          refill_req <= 1'b0;
          ready      <= 1'b1;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_replacement_controller.sv
// Self-checking bench for replacement_controller: directed cases plus
// randomized hit/miss traffic against a rule-level victim/latency model.
module tb_replacement_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       lookup_valid = 1'b0;
  logic [7:0] lookup_index = '0;
  logic       hit = 1'b0;
  logic [1:0] hit_way = '0;
  logic [3:0] valid_bits = '0;
  logic [3:0] dirty_bits = '0;
  logic [3:0] lru_onehot = '0;
  logic       wb_ack = 1'b0;
  logic       refill_ack = 1'b0;

  logic       ready;
  logic [7:0] lru_index;
  logic [1:0] lru_access;
  logic       lru_access_valid;
  logic [1:0] victim_way;
  logic       wb_req;
  logic       refill_req;
  logic       miss_done;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;

  replacement_controller #(.NUM_WAYS(4), .INDEX_BITS(8)) dut (
    .clock            (clock),
    .reset            (reset),
    .lookup_valid     (lookup_valid),
    .lookup_index     (lookup_index),
    .hit              (hit),
    .hit_way          (hit_way),
    .valid_bits       (valid_bits),
    .dirty_bits       (dirty_bits),
    .ready            (ready),
    .lru_index        (lru_index),
    .lru_access       (lru_access),
    .lru_access_valid (lru_access_valid),
    .lru_onehot       (lru_onehot),
    .victim_way       (victim_way),
    .wb_req           (wb_req),
    .wb_ack           (wb_ack),
    .refill_req       (refill_req),
    .refill_ack       (refill_ack),
    .miss_done        (miss_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Rule: first invalid way, else first way flagged by LRU, else way 0.
  function automatic logic [1:0] exp_victim(input logic [3:0] v, input logic [3:0] l);
    for (int w = 0; w < 4; w++) if (!v[w]) return 2'(w);
    for (int w = 0; w < 4; w++) if (l[w]) return 2'(w);
    return 2'd0;
  endfunction

  task automatic do_hit(input logic [7:0] idx, input logic [1:0] way);
    lookup_valid = 1'b1; hit = 1'b1; lookup_index = idx; hit_way = way;
    tick();
    lookup_valid = 1'b0; hit = 1'b0;
    chk("hit_lav", 32'(lru_access_valid), 32'd1);
    chk("hit_way", 32'(lru_access), 32'(way));
    chk("hit_index", 32'(lru_index), 32'(idx));
    chk("hit_ready", 32'(ready), 32'd1);
    tick();
    chk("hit_lav_drop", 32'(lru_access_valid), 32'd0);
  endtask

  task automatic do_miss(input logic [7:0] idx, input logic [3:0] v, input logic [3:0] d,
                         input logic [3:0] l, input int unsigned wbw, input int unsigned rfw,
                         input bit busy_lookups, input bit spur_ack);
    logic [1:0]  ev;
    bit          edirty;
    int unsigned t0;
    ev     = exp_victim(v, l);
    edirty = (v == 4'hF) && d[ev];
    chk("miss_ready_in", 32'(ready), 32'd1);
    lookup_valid = 1'b1; hit = 1'b0; lookup_index = idx; valid_bits = v; dirty_bits = d;
    tick();
    t0 = cyc;
    // Busy-time lookups are hits with junk set state; any acceptance shows as an LRU pulse.
    lookup_valid = busy_lookups; hit = 1'b1; hit_way = 2'($urandom);
    lookup_index = 8'($urandom); valid_bits = 4'($urandom); dirty_bits = 4'($urandom);
    lru_onehot = l;
    if (spur_ack) begin wb_ack = 1'b1; refill_ack = 1'b1; end
    chk("sel_ready", 32'(ready), 32'd0);
    chk("sel_wb_req", 32'(wb_req), 32'd0);
    chk("sel_refill_req", 32'(refill_req), 32'd0);
    chk("sel_lav", 32'(lru_access_valid), 32'd0);
    tick();
    wb_ack = 1'b0; refill_ack = 1'b0; lru_onehot = 4'($urandom);
    chk("victim_way", 32'(victim_way), 32'(ev));
    if (edirty) begin
      for (int unsigned i = 0; i < wbw; i++) begin
        chk("wb_req_hold", 32'(wb_req), 32'd1);
        chk("wb_no_refill", 32'(refill_req), 32'd0);
        chk("wb_lav", 32'(lru_access_valid), 32'd0);
        tick();
      end
      chk("wb_req_at_ack", 32'(wb_req), 32'd1);
      wb_ack = 1'b1;
      tick();
      wb_ack = 1'b0;
    end
    for (int unsigned i = 0; i < rfw; i++) begin
      chk("rf_req_hold", 32'(refill_req), 32'd1);
      chk("rf_no_wb", 32'(wb_req), 32'd0);
      chk("rf_ready", 32'(ready), 32'd0);
      tick();
    end
    chk("rf_req_at_ack", 32'(refill_req), 32'd1);
    chk("rf_wb_low", 32'(wb_req), 32'd0);
    chk("rf_victim_stable", 32'(victim_way), 32'(ev));
    refill_ack = 1'b1;
    tick();
    refill_ack = 1'b0;
    chk("upd_miss_done", 32'(miss_done), 32'd1);
    chk("upd_lav", 32'(lru_access_valid), 32'd1);
    chk("upd_access", 32'(lru_access), 32'(ev));
    chk("upd_index", 32'(lru_index), 32'(idx));
    chk("upd_refill_drop", 32'(refill_req), 32'd0);
    chk("upd_ready", 32'(ready), 32'd0);
    chk("miss_latency", cyc - t0, 32'(2 + (edirty ? wbw + 1 : 0) + rfw));
    lookup_valid = 1'b0; hit = 1'b0;
    tick();
    chk("done_drop", 32'(miss_done), 32'd0);
    chk("done_lav_drop", 32'(lru_access_valid), 32'd0);
    chk("done_ready", 32'(ready), 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_lru_index", 32'(lru_index), 32'd0);
    chk("rst_lru_access", 32'(lru_access), 32'd0);
    chk("rst_victim", 32'(victim_way), 32'd0);
    chk("rst_lav", 32'(lru_access_valid), 32'd0);
    chk("rst_wb_req", 32'(wb_req), 32'd0);
    chk("rst_refill_req", 32'(refill_req), 32'd0);
    chk("rst_miss_done", 32'(miss_done), 32'd0);

    do_hit(8'd1, 2'd2);

    // Back-to-back hits: one update per cycle.
    for (int i = 0; i < 4; i++) begin
      lookup_valid = 1'b1; hit = 1'b1; lookup_index = 8'(10 + i); hit_way = 2'(i);
      tick();
      chk("b2b_lav", 32'(lru_access_valid), 32'd1);
      chk("b2b_way", 32'(lru_access), 32'(i));
      chk("b2b_index", 32'(lru_index), 32'(10 + i));
    end
    lookup_valid = 1'b0; hit = 1'b0;
    tick();
    chk("b2b_lav_drop", 32'(lru_access_valid), 32'd0);

    do_miss(8'h20, 4'b1011, 4'b1111, 4'b1000, 0, 0, 1'b0, 1'b0);
    do_miss(8'h21, 4'b1111, 4'b0001, 4'b0001, 3, 0, 1'b0, 1'b1);
    do_miss(8'h22, 4'b1111, 4'b0000, 4'b1000, 0, 0, 1'b1, 1'b0);
    do_miss(8'h23, 4'b1111, 4'b0000, 4'b0110, 0, 1, 1'b0, 1'b0);
    do_miss(8'h24, 4'b1111, 4'b0000, 4'b0000, 1, 0, 1'b0, 1'b0);

    // Reset while a writeback is outstanding.
    lookup_valid = 1'b1; hit = 1'b0; lookup_index = 8'h30;
    valid_bits = 4'b1111; dirty_bits = 4'b0100; lru_onehot = 4'b0100;
    tick();
    lookup_valid = 1'b0;
    tick();
    chk("mid_wb_req", 32'(wb_req), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_wb_req", 32'(wb_req), 32'd0);
    chk("mid_rst_refill", 32'(refill_req), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_done", 32'(miss_done), 32'd0);
    chk("mid_rst_lav", 32'(lru_access_valid), 32'd0);
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    chk("post_rst_done", 32'(miss_done), 32'd0);
    chk("post_rst_refill", 32'(refill_req), 32'd0);
    chk("post_rst_ready", 32'(ready), 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_hit(8'($urandom), 2'($urandom));
      end else begin
        logic [3:0] v;
        v = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
        do_miss(8'($urandom), v, 4'($urandom), 4'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), 1'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
